shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
// - Upstream control stage for the combinational barrel_shifter. Accepts one shift request
//   (data, total amount, direction) over a valid/ready handshake.
// - Amounts larger than one shifter pass are split into several passes. Each pass drives the
//   external shifter (bs_in/bs_sel/bs_sft_lft) and registers its result (bs_out).
// - Returns the final word on a valid/ready response port. One request in flight at a time.
// PARAMETERS
// - WIDTH  8  data width; equals the attached barrel_shifter width
// - SEL_W  2  barrel_shifter select width; max shift per pass MAXP = 2**SEL_W-1
// - AMT_W  3  width of the total requested shift amount (0 .. 2**AMT_W-1)
// PORTS
// - clk         in   1      single clock, rising edge
// - rst         in   1      asynchronous reset, active high
// - req_valid   in   1      request present
// - req_ready   out  1      block can accept a request (high only in IDLE)
// - req_data    in   WIDTH  word to shift
// - req_amt     in   AMT_W  total shift amount
// - req_lft     in   1      1 = shift left, 0 = shift right
// - bs_in       out  WIDTH  to barrel_shifter in
// - bs_sel      out  SEL_W  to barrel_shifter sel (amount for this pass)
// - bs_sft_lft  out  1      to barrel_shifter sft_lft
// - bs_out      in   WIDTH  from barrel_shifter out (combinational result)
// - rsp_valid   out  1      result available
// - rsp_ready   in   1      consumer takes result
// - rsp_data    out  WIDTH  shifted result
// - busy        out  1      state != IDLE
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=IDLE; acc=0, rem=0, dir=0.
//   - rsp_valid=0, rsp_data=0, busy=0, req_ready=1.
//   - bs_in=0, bs_sel=0, bs_sft_lft=0.
// - Attached shifter is logical with zero fill. This block never wraps bits.
// - FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: req_ready=1. On req_valid at an edge, latch acc=req_data, rem=req_amt, dir=req_lft.
//     If req_amt==0, go to DONE; else go to SHIFT.
//   - SHIFT: drive bs_in=acc, bs_sel=step=min(rem,MAXP), bs_sft_lft=dir.
//     Each edge: acc<=bs_out, rem<=rem-step. When rem==step, go to DONE.
//   - DONE: rsp_valid=1, rsp_data=acc, both held stable until rsp_ready. On rsp_valid&rsp_ready
//     at an edge, go to IDLE.
// - Outside SHIFT: bs_in=acc, bs_sel=0, bs_sft_lft=dir. bs_* outputs are registered-state
//   driven and glitch free.
// - Latency: P = ceil(req_amt/MAXP) SHIFT cycles. rsp_valid rises P+1 edges after the accept
//   edge (1 edge when amt=0).
// - Amounts >= WIDTH still iterate fully; the result is all zeros.
// - No new request is accepted in SHIFT or DONE; req_valid there is ignored. No combinational
//   path from rsp_ready to req_ready: throughput is one request per P+2 cycles minimum.
// - rsp_ready high while not in DONE has no effect.
// - Reset mid-SHIFT or mid-DONE aborts the operation immediately. The pending result is
//   discarded; no rsp_valid pulse.
// TESTING
// - Reset: assert rst mid-cycle -> outputs at reset values immediately, req_ready=1, busy=0.
// - 0xB5, amt 5, left -> bs_sel 3 then 2; rsp_data 0xA0; rsp_valid 3 edges after accept.
// - 0xB5, amt 7, right -> bs_sel 3,3,1; rsp_data 0x01; busy high 4 cycles.
// - 0x3C, amt 0, left -> no SHIFT cycle; rsp_data 0x3C; rsp_valid 1 edge after accept.
// - Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_data stable, req_ready=0, a
//   second req_valid is not accepted until one edge after the response handshake.
// - Reset during SHIFT of 0xFF amt 6 -> no rsp_valid; a following 0x01 amt 1 left -> 0x02.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: control stage in front of a combinational logical barrel shifter.
// Takes one request (data, total amount, direction) and splits the amount into passes
// of at most MAXP bit positions. Each pass goes through the external shifter, and the
// result is captured on the next edge. The final word is returned over a valid/ready
// response port. Only one request is in flight at a time.
// Every output comes straight from a register, so bs_* never glitches.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_lft,
    output logic [WIDTH-1:0] bs_in,
    output logic [SEL_W-1:0] bs_sel,
    output logic             bs_sft_lft,
    input  logic [WIDTH-1:0] bs_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int MAXP = (1 << SEL_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_s;
    logic [AMT_W-1:0] rem_r;
    logic [AMT_W-1:0] rem_s;
    logic             dir_r;
    logic             dir_s;
    logic [SEL_W-1:0] step_s;
    logic [SEL_W-1:0] bs_sel_r;
    logic [SEL_W-1:0] bs_sel_s;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic             busy_r;

    // Size of one pass: the remaining amount, capped at what the shifter can do at once.
    function automatic logic [SEL_W-1:0] step_of(input logic [AMT_W-1:0] rem);
        logic [SEL_W-1:0] s;
        if (int'(rem) > MAXP) begin
            s = SEL_W'(MAXP);
        end else begin
            s = SEL_W'(rem);
        end
        return s;
    endfunction

    assign step_s = step_of(rem_r);

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        rem_s    = rem_r;
        dir_s    = dir_r;
        bs_sel_s = {SEL_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    acc_s = req_data;
                    rem_s = req_amt;
                    dir_s = req_lft;
                    if (req_amt == {AMT_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                acc_s = bs_out;
                rem_s = rem_r - AMT_W'(step_s);
                if (rem_r == AMT_W'(step_s)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // The pass amount for the next cycle is prepared here so that bs_sel can be a register.
        if (state_s == SHIFT) begin
            bs_sel_s = step_of(rem_s);
        end else begin
            bs_sel_s = {SEL_W{1'b0}};
        end
    end

    // State, datapath and registered output flags; rst aborts any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {WIDTH{1'b0}};
            rem_r       <= {AMT_W{1'b0}};
            dir_r       <= 1'b0;
            bs_sel_r    <= {SEL_W{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            rem_r       <= rem_s;
            dir_r       <= dir_s;
            bs_sel_r    <= bs_sel_s;
            req_ready_r <= (state_s == IDLE);
            rsp_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign bs_in      = acc_r;
    assign bs_sel     = bs_sel_r;
    assign bs_sft_lft = dir_r;
    assign rsp_data   = acc_r;
    assign rsp_valid  = rsp_valid_r;
    assign req_ready  = req_ready_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer. The bench provides a logical zero-fill barrel shifter,
// runs a table of directed vectors, hand-written backpressure and reset sequences, and
// random requests that are checked against a bit-at-a-time reference model.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
    localparam int AMT_W = 3;
    localparam int MAXP  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_lft;
    logic [WIDTH-1:0] bs_in;
    logic [SEL_W-1:0] bs_sel;
    logic             bs_sft_lft;
    logic [WIDTH-1:0] bs_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [SEL_W-1:0] sel_q[$];
    bit               cap_on = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [2:0] amt;
        bit         lft;
        int         bp;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    shift_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_amt(req_amt), .req_lft(req_lft),
        .bs_in(bs_in), .bs_sel(bs_sel), .bs_sft_lft(bs_sft_lft), .bs_out(bs_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    // Attached shifter: logical, zero fill.
    assign bs_out = bs_sft_lft ? (bs_in << bs_sel) : (bs_in >> bs_sel);

    // Free-running clock.
    always #5 clk = ~clk;

    // Record the pass amount seen during each shift cycle of the current request.
    always @(negedge clk) begin
        if (cap_on && bs_sel != 2'd0) sel_q.push_back(bs_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: shift one bit position at a time, with zero fill.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input bit lft);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < amt; i++) r = lft ? (r << 1) : (r >> 1);
        return r;
    endfunction

    task automatic chk_reset_vals(input string name);
        chk({name, " req_ready"}, 32'(req_ready), 32'd1);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, " rsp_data"}, 32'(rsp_data), 32'd0);
        chk({name, " bs_in"}, 32'(bs_in), 32'd0);
        chk({name, " bs_sel"}, 32'(bs_sel), 32'd0);
        chk({name, " bs_sft_lft"}, 32'(bs_sft_lft), 32'd0);
    endtask

    task automatic wait_rsp(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk({name, " rsp_valid timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_req(input string name, input logic [7:0] d, input logic [2:0] amt,
                           input bit lft, input int bp, input logic [7:0] exp_d,
                           input int exp_lat, input bit noise);
        int         edges;
        int         busy_cnt;
        int         w;
        int         rem;
        int         st;
        int         idx;
        logic [7:0] held;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, " req_ready"}, 32'(req_ready), 32'd1);
        sel_q.delete();
        cap_on    = 1'b1;
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = amt;
        req_lft   = lft;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        edges     = 1;
        busy_cnt  = 0;
        while (edges < 30) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            if (rsp_valid) break;
            if (noise) begin
                req_valid = 1'($urandom);
                rsp_ready = 1'($urandom);
                req_amt   = 3'($urandom);
            end
            @(posedge clk);
            edges++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        cap_on    = 1'b0;
        chk({name, " latency"}, 32'(edges), 32'(exp_lat));
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
        rem = int'(amt);
        idx = 0;
        while (rem > 0) begin
            st = (rem > MAXP) ? MAXP : rem;
            if (idx < sel_q.size()) chk({name, " bs_sel pass"}, 32'(sel_q[idx]), 32'(st));
            else chk({name, " bs_sel missing pass"}, 32'hFFFF, 32'(st));
            idx++;
            rem -= st;
        end
        chk({name, " pass count"}, 32'(sel_q.size()), 32'(idx));
        held = rsp_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            chk({name, " bp rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, " bp rsp_data"}, 32'(rsp_data), 32'(held));
            chk({name, " bp req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, " post req_ready"}, 32'(req_ready), 32'd1);
        chk({name, " post busy"}, 32'(busy), 32'd0);
        chk({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat + bp));
    endtask

    // Main stimulus sequence.
    initial begin
        vec_t       vecs[$];
        logic [7:0] d;
        logic [2:0] a;
        bit         l;
        int         bp;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 8'd0;
        req_amt   = 3'd0;
        req_lft   = 1'b0;
        rsp_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{"b5_l5", 8'hB5, 3'd5, 1'b1, 0, 8'hA0, 3});
        vecs.push_back('{"b5_r7", 8'hB5, 3'd7, 1'b0, 0, 8'h01, 4});
        vecs.push_back('{"3c_l0", 8'h3C, 3'd0, 1'b1, 0, 8'h3C, 1});
        vecs.push_back('{"81_r3", 8'h81, 3'd3, 1'b0, 1, 8'h10, 2});
        vecs.push_back('{"ff_l6", 8'hFF, 3'd6, 1'b1, 2, 8'hC0, 3});
        vecs.push_back('{"5a_r4", 8'h5A, 3'd4, 1'b0, 0, 8'h05, 3});
        foreach (vecs[i]) begin
            run_req(vecs[i].name, vecs[i].data, vecs[i].amt, vecs[i].lft, vecs[i].bp,
                    vecs[i].exp_data, vecs[i].exp_lat, 1'b0);
        end

        // Backpressure in DONE with a second request waiting.
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 8'hB5;
        req_amt   = 3'd5;
        req_lft   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp("bp");
        chk("bp first data", 32'(rsp_data), 32'hA0);
        req_valid = 1'b1;
        req_data  = 8'h0F;
        req_amt   = 3'd1;
        req_lft   = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp hold rsp_data", 32'(rsp_data), 32'hA0);
            chk("bp hold req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp handshake rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp handshake req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp second busy", 32'(busy), 32'd1);
        chk("bp second req_ready", 32'(req_ready), 32'd0);
        wait_rsp("bp second");
        chk("bp second data", 32'(rsp_data), 32'h07);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp second done", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a multi-pass operation.
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 8'hFF;
        req_amt   = 3'd6;
        req_lft   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("mid reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid reset no rsp", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        run_req("after reset", 8'h01, 3'd1, 1'b1, 0, 8'h02, 2, 1'b0);

        // Random requests against the reference model.
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            a  = 3'($urandom_range(0, 7));
            l  = 1'($urandom);
            bp = int'($urandom_range(0, 2));
            run_req("rand", d, a, l, bp, ref_shift(d, int'(a), l),
                    (int'(a) + MAXP - 1) / MAXP + 1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
